// File: rtl/retire_pkg.sv
// Shared types for the in-order retirement buffer: entry layout, tag type and
// the default depth. Register-index and data widths come from the global macros.
`ifndef NUMBER_OF_REGISTERS_B
`define NUMBER_OF_REGISTERS_B 5
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package retire_pkg;

  localparam int RETIRE_DEPTH = 8;
  localparam int RETIRE_TAG_W = $clog2(RETIRE_DEPTH);

  typedef logic [RETIRE_TAG_W-1:0]          retire_tag_t;
  typedef logic [`NUMBER_OF_REGISTERS_B-1:0] retire_rd_t;
  typedef logic [`DATA_SIZE-1:0]             retire_data_t;

  typedef struct packed {
    logic         valid;
    logic         done;
    logic         wen;
    retire_rd_t   rd;
    retire_data_t data;
  } retire_entry_t;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/retire_buffer.sv
// In-order retirement buffer: allocate at tail, complete out of order by tag,
// retire at most one done head entry per cycle into a registered regfile write port.
`ifndef NUMBER_OF_REGISTERS_B
`define NUMBER_OF_REGISTERS_B 5
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module retire_buffer
  import retire_pkg::*;
#(
  parameter int DEPTH = RETIRE_DEPTH,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              alloc_valid,
  input  logic                              alloc_wen,
  input  logic [`NUMBER_OF_REGISTERS_B-1:0] alloc_rd,
  output logic                              alloc_ready,
  output logic [TAG_W-1:0]                  alloc_tag,
  input  logic                              cmpl_valid,
  input  logic [TAG_W-1:0]                  cmpl_tag,
  input  logic [`DATA_SIZE-1:0]             cmpl_data,
  output logic                              regwr,
  output logic [`NUMBER_OF_REGISTERS_B-1:0] rd,
  output logic [`DATA_SIZE-1:0]             data,
  output logic                              empty,
  output logic [$clog2(DEPTH+1)-1:0]        count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  retire_entry_t entries_q [DEPTH];
  retire_entry_t entries_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             regwr_q, regwr_d;
  retire_rd_t       rd_q, rd_d;
  retire_data_t     data_q, data_d;

  logic alloc_fire;
  logic cmpl_fire;
  logic retire_fire;

  // Readiness looks only at the registered count, so a same-cycle retirement
  // never opens a slot for that cycle's allocation.
  assign alloc_ready = !reset && (count_q < FULL_COUNT);
  assign alloc_tag   = tail_q;
  assign regwr       = regwr_q;
  assign rd          = rd_q;
  assign data        = data_q;
  assign count       = count_q;
  assign empty       = (count_q == '0);

  always_comb begin
    alloc_fire  = alloc_valid && alloc_ready;
    cmpl_fire   = cmpl_valid && entries_q[cmpl_tag].valid && !entries_q[cmpl_tag].done;
    retire_fire = entries_q[head_q].valid && entries_q[head_q].done;

    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    regwr_d   = 1'b0;
    rd_d      = rd_q;
    data_d    = data_q;

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Retirement is judged on registered done bits, so a completion to the
      // head this cycle is seen one cycle later.
      if (retire_fire) begin
        entries_d[head_q].valid = 1'b0;
        head_d  = head_q + TAG_W'(1);
        regwr_d = entries_q[head_q].wen && (entries_q[head_q].rd != '0);
        rd_d    = entries_q[head_q].rd;
        data_d  = entries_q[head_q].data;
      end
      if (cmpl_fire) begin
        entries_d[cmpl_tag].done = 1'b1;
        entries_d[cmpl_tag].data = cmpl_data;
      end
      if (alloc_fire) begin
        entries_d[tail_q].valid = 1'b1;
        entries_d[tail_q].done  = 1'b0;
        entries_d[tail_q].wen   = alloc_wen;
        entries_d[tail_q].rd    = alloc_rd;
        tail_d = tail_q + TAG_W'(1);
      end
      case ({alloc_fire, retire_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i].valid <= 1'b0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      regwr_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      regwr_q   <= regwr_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    assert (is_pow2(DEPTH));
    if (!reset && !flush && cmpl_valid) begin
      assert (entries_q[cmpl_tag].valid);
    end
  end

endmodule

// File: tb/tb_retire_buffer.sv
// Bench for retire_buffer: directed vector table, hand-written full/wrap and
// flush sequences, then random traffic checked against an in-order queue model.
`ifndef NUMBER_OF_REGISTERS_B
`define NUMBER_OF_REGISTERS_B 5
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module tb_retire_buffer;

  localparam int RW = `NUMBER_OF_REGISTERS_B;
  localparam int DW = `DATA_SIZE;
  localparam int NV = 25;

  logic          clk = 1'b0;
  logic          reset, flush;
  logic          alloc_valid, alloc_wen;
  logic [RW-1:0] alloc_rd;
  logic          alloc_ready;
  logic [2:0]    alloc_tag;
  logic          cmpl_valid;
  logic [2:0]    cmpl_tag;
  logic [DW-1:0] cmpl_data;
  logic          regwr;
  logic [RW-1:0] rd;
  logic [DW-1:0] data;
  logic          empty;
  logic [3:0]    count;

  retire_buffer #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_wen(alloc_wen), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_data(cmpl_data),
    .regwr(regwr), .rd(rd), .data(data), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          av;
    logic          aw;
    logic [RW-1:0] ard;
    logic          cv;
    logic [2:0]    ct;
    logic [DW-1:0] cd;
    logic          ew;
    logic [RW-1:0] erd;
    logic [DW-1:0] ed;
    int            ecnt;
    int            etag;
  } vec_t;

  typedef struct {
    int            tag;
    bit            wen;
    bit [RW-1:0]   rd;
    bit            done;
    bit [DW-1:0]   data;
  } mentry_t;

  vec_t    vecs [NV];
  mentry_t q [$];

  function automatic vec_t V(input logic av, input logic aw, input logic [RW-1:0] ard,
                             input logic cv, input logic [2:0] ct, input logic [DW-1:0] cd,
                             input logic ew, input logic [RW-1:0] erd, input logic [DW-1:0] ed,
                             input int ecnt, input int etag);
    vec_t v;
    v.av = av; v.aw = aw; v.ard = ard; v.cv = cv; v.ct = ct; v.cd = cd;
    v.ew = ew; v.erd = erd; v.ed = ed; v.ecnt = ecnt; v.etag = etag;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; alloc_valid = 1'b0; alloc_wen = 1'b0; alloc_rd = '0;
    cmpl_valid = 1'b0; cmpl_tag = '0; cmpl_data = '0;
  endtask

  task automatic do_reset(input bit full_check);
    reset = 1'b1; flush = 1'b1; alloc_valid = 1'b1; alloc_wen = 1'b1; alloc_rd = '1;
    cmpl_valid = 1'b1; cmpl_tag = '0; cmpl_data = '1;
    repeat (2) begin
      tick();
      if (full_check) begin
        check("rst_regwr", regwr, 0);
        check("rst_rd", rd, 0);
        check("rst_data", data, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_alloc_tag", alloc_tag, 0);
        check("rst_alloc_ready_low", alloc_ready, 0);
      end
    end
    reset = 1'b0;
    idle();
    #1;
    if (full_check) check("rst_alloc_ready_after", alloc_ready, 1);
  endtask

  int  m_tail;
  bit  do_flush, ready, retiring, exp_regwr;
  bit [RW-1:0] m_rd;
  bit [DW-1:0] m_data;
  mentry_t me;
  int  k;

  initial begin
    vecs[0]  = V(1,1,5, 0,0,0,            0,0,0,            1,1);
    vecs[1]  = V(0,0,0, 1,0,32'hDEADBEEF, 0,0,0,            1,1);
    vecs[2]  = V(0,0,0, 0,0,0,            1,5,32'hDEADBEEF, 0,1);
    vecs[3]  = V(0,0,0, 0,0,0,            0,5,32'hDEADBEEF, 0,1);
    vecs[4]  = V(1,1,1, 0,0,0,            0,5,32'hDEADBEEF, 1,2);
    vecs[5]  = V(1,1,2, 0,0,0,            0,5,32'hDEADBEEF, 2,3);
    vecs[6]  = V(1,1,3, 0,0,0,            0,5,32'hDEADBEEF, 3,4);
    vecs[7]  = V(0,0,0, 1,3,32'h33,       0,5,32'hDEADBEEF, 3,4);
    vecs[8]  = V(0,0,0, 1,2,32'h22,       0,5,32'hDEADBEEF, 3,4);
    vecs[9]  = V(0,0,0, 1,1,32'h11,       0,5,32'hDEADBEEF, 3,4);
    vecs[10] = V(0,0,0, 0,0,0,            1,1,32'h11,       2,4);
    vecs[11] = V(0,0,0, 0,0,0,            1,2,32'h22,       1,4);
    vecs[12] = V(0,0,0, 0,0,0,            1,3,32'h33,       0,4);
    vecs[13] = V(0,0,0, 0,0,0,            0,3,32'h33,       0,4);
    vecs[14] = V(1,1,0, 0,0,0,            0,3,32'h33,       1,5);
    vecs[15] = V(1,0,7, 0,0,0,            0,3,32'h33,       2,6);
    vecs[16] = V(1,1,9, 0,0,0,            0,3,32'h33,       3,7);
    vecs[17] = V(0,0,0, 1,6,32'h99,       0,3,32'h33,       3,7);
    vecs[18] = V(0,0,0, 1,6,32'h55,       0,3,32'h33,       3,7);
    vecs[19] = V(0,0,0, 1,4,32'h10,       0,3,32'h33,       3,7);
    vecs[20] = V(0,0,0, 0,0,0,            0,0,32'h10,       2,7);
    vecs[21] = V(0,0,0, 1,5,32'h20,       0,0,32'h10,       2,7);
    vecs[22] = V(0,0,0, 0,0,0,            0,7,32'h20,       1,7);
    vecs[23] = V(0,0,0, 0,0,0,            1,9,32'h99,       0,7);
    vecs[24] = V(0,0,0, 0,0,0,            0,9,32'h99,       0,7);

    idle();
    do_reset(1'b1);

    // Single path, out-of-order completion, rd=0 / wen=0 / duplicate completion.
    for (int i = 0; i < NV; i++) begin
      idle();
      alloc_valid = vecs[i].av; alloc_wen = vecs[i].aw; alloc_rd = vecs[i].ard;
      cmpl_valid = vecs[i].cv; cmpl_tag = vecs[i].ct; cmpl_data = vecs[i].cd;
      tick();
      $display("vec %0d: regwr=%0b rd=%0d data=%h count=%0d tag=%0d",
               i, regwr, rd, data, count, alloc_tag);
      check($sformatf("v%0d_regwr", i), regwr, vecs[i].ew);
      check($sformatf("v%0d_rd", i), rd, vecs[i].erd);
      check($sformatf("v%0d_data", i), data, vecs[i].ed);
      check($sformatf("v%0d_count", i), count, vecs[i].ecnt);
      check($sformatf("v%0d_alloc_tag", i), alloc_tag, vecs[i].etag);
      check($sformatf("v%0d_empty", i), empty, vecs[i].ecnt == 0);
    end

    // Fill to capacity, then show that a same-cycle retirement does not admit an allocation.
    idle();
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1; alloc_wen = 1'b1; alloc_rd = RW'(i + 1);
      #0;
      check($sformatf("full_alloc_tag%0d", i), alloc_tag, i);
      tick();
    end
    check("full_count", count, 8);
    check("full_ready", alloc_ready, 0);
    check("full_tag_wrapped", alloc_tag, 0);
    alloc_rd = 5'd20;
    cmpl_valid = 1'b1; cmpl_tag = 3'd0; cmpl_data = 32'hA0;
    tick();
    check("full_no_alloc_count", count, 8);
    cmpl_valid = 1'b0;
    check("full_ready_while_retiring", alloc_ready, 0);
    tick();
    check("full_retire_count", count, 7);
    check("full_retire_regwr", regwr, 1);
    check("full_retire_rd", rd, 1);
    check("full_retire_data", data, 32'hA0);
    check("wrap_ready", alloc_ready, 1);
    check("wrap_tag", alloc_tag, 0);
    tick();
    check("wrap_count", count, 8);
    check("wrap_next_tag", alloc_tag, 1);
    $display("full/wrap sequence: count=%0d tag=%0d", count, alloc_tag);
    idle();

    // Flush beats a same-cycle allocate and completion.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1; alloc_wen = 1'b1; alloc_rd = RW'(i + 1);
      tick();
    end
    idle();
    cmpl_valid = 1'b1; cmpl_tag = 3'd1; cmpl_data = 32'h111;
    tick();
    cmpl_tag = 3'd3; cmpl_data = 32'h333;
    tick();
    check("flush_pre_count", count, 4);
    flush = 1'b1; alloc_valid = 1'b1; alloc_wen = 1'b1; alloc_rd = 5'd6;
    cmpl_valid = 1'b1; cmpl_tag = 3'd2; cmpl_data = 32'h222;
    tick();
    idle();
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_regwr", regwr, 0);
    check("flush_tag", alloc_tag, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("flush_quiet%0d_regwr", i), regwr, 0);
      check($sformatf("flush_quiet%0d_count", i), count, 0);
    end
    alloc_valid = 1'b1; alloc_wen = 1'b1; alloc_rd = 5'd7;
    #0;
    check("flush_next_tag", alloc_tag, 0);
    tick();
    check("flush_next_count", count, 1);
    $display("flush sequence: count=%0d tag=%0d", count, alloc_tag);
    idle();

    // Randomized traffic against a program-order queue model.
    do_reset(1'b0);
    q.delete();
    m_tail = 0; m_rd = '0; m_data = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      do_flush    = ($urandom_range(0, 63) == 0);
      flush       = do_flush;
      alloc_valid = ($urandom_range(0, 9) < 6);
      alloc_wen   = 1'($urandom);
      alloc_rd    = RW'($urandom);
      if (q.size() > 0 && $urandom_range(0, 9) < 6) begin
        k = $urandom_range(0, q.size() - 1);
        cmpl_valid = 1'b1;
        cmpl_tag   = 3'(q[k].tag);
        cmpl_data  = DW'($urandom);
      end else begin
        cmpl_valid = 1'b0;
        cmpl_tag   = '0;
        cmpl_data  = '0;
      end
      #1;
      check("rnd_alloc_ready", alloc_ready, q.size() < 8);
      check("rnd_alloc_tag", alloc_tag, m_tail);

      exp_regwr = 1'b0;
      if (do_flush) begin
        q.delete();
        m_tail = 0;
      end else begin
        ready    = (q.size() < 8);
        retiring = (q.size() > 0) && q[0].done;
        if (retiring) begin
          exp_regwr = q[0].wen && (q[0].rd != 0);
          m_rd      = q[0].rd;
          m_data    = q[0].data;
        end
        if (cmpl_valid) begin
          foreach (q[j]) begin
            if (q[j].tag == int'(cmpl_tag) && !q[j].done) begin
              q[j].done = 1'b1;
              q[j].data = cmpl_data;
            end
          end
        end
        if (retiring) void'(q.pop_front());
        if (alloc_valid && ready) begin
          me.tag = m_tail; me.wen = alloc_wen; me.rd = alloc_rd; me.done = 1'b0; me.data = '0;
          q.push_back(me);
          m_tail = (m_tail + 1) % 8;
        end
      end

      tick();
      check("rnd_regwr", regwr, exp_regwr);
      check("rnd_rd", rd, m_rd);
      check("rnd_data", data, m_data);
      check("rnd_count", count, q.size());
      check("rnd_empty", empty, q.size() == 0);
    end
    idle();
    $display("random traffic: 2000 cycles, final count=%0d", count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
